// File: rtl/sample_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_capture_if : trigger, ADC SPI and sample readout signal group  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface sample_capture_if #(
  parameter int ADC_BITS   = 12,
  parameter int FIFO_DEPTH = 16
) ();
  logic                          do_sample;
  logic                          adc_cs_n;
  logic                          adc_sclk;
  logic                          adc_miso;
  logic [ADC_BITS-1:0]           sample_data;
  logic [7:0]                    sample_index;
  logic                          sample_valid;
  logic                          sample_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic [7:0]                    missed_count;
  logic [7:0]                    overrun_count;

  // master: the capture block; slave: its environment (trigger source, ADC, reader)
  modport master (
    input  do_sample, adc_miso, sample_ready,
    output adc_cs_n, adc_sclk, sample_data, sample_index, sample_valid,
           fifo_level, missed_count, overrun_count
  );
  modport slave (
    output do_sample, adc_miso, sample_ready,
    input  adc_cs_n, adc_sclk, sample_data, sample_index, sample_valid,
           fifo_level, missed_count, overrun_count
  );
endinterface
`default_nettype wire

// File: rtl/sample_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_capture : DO_SAMPLE-edge triggered SPI ADC reader with tagged  |
// |                  first-word-fall-through result FIFO                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sample_capture #(
  parameter int ADC_BITS   = 12,
  parameter int LEAD_BITS  = 3,
  parameter int FRAME_BITS = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic          i_clk_500k,
  input  wire logic          i_rst_n,
  sample_capture_if.master   io_cap
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_BW = $clog2(FRAME_BITS + 1);
  localparam int c_EW = ADC_BITS + 8;

  localparam logic [c_BW-1:0] c_LEAD     = c_BW'(LEAD_BITS);
  localparam logic [c_BW-1:0] c_DATA_END = c_BW'(LEAD_BITS + ADC_BITS);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(FRAME_BITS - 1);
  localparam logic [c_LW-1:0] c_DEPTH    = c_LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_do_d;
  logic                  r_cs_n;
  logic                  r_sclk;
  logic [c_BW-1:0]       r_bit;
  logic [ADC_BITS-1:0]   r_shift;
  logic [7:0]            r_next_idx;
  logic [7:0]            r_missed;
  logic [7:0]            r_overrun;

  logic [c_EW-1:0]       r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_LW-1:0]       r_level;
  logic [ADC_BITS-1:0]   r_data;
  logic [7:0]            r_index;

  logic                  w_trig;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_ok;
  logic [c_AW-1:0]       w_rd_next;
  logic [c_LW-1:0]       w_level_next;
  logic [c_LW-1:0]       w_keep;
  logic [c_EW-1:0]       w_entry;

  assign w_trig       = io_cap.do_sample ^ r_do_d;
  assign w_push       = (r_state == S_DONE);
  assign w_pop        = (r_level != '0) && io_cap.sample_ready;
  // A full FIFO still accepts the push when the head leaves on the same edge
  assign w_push_ok    = w_push && ((r_level != c_DEPTH) || w_pop);
  assign w_rd_next    = r_rd_ptr + c_AW'(w_pop);
  assign w_keep       = r_level - c_LW'(w_pop);
  assign w_level_next = w_keep + c_LW'(w_push_ok);
  assign w_entry      = {r_shift, r_next_idx};

  always_ff @(posedge i_clk_500k) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_do_d     <= io_cap.do_sample;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_next_idx <= '0;
      r_missed   <= '0;
      r_overrun  <= '0;
    end else begin
      r_do_d <= io_cap.do_sample;
      if (w_trig && (r_state != S_IDLE) && (r_missed != 8'hFF)) begin
        r_missed <= r_missed + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state <= S_SETUP;
            r_cs_n  <= 1'b0;
          end
        end
        S_SETUP: begin
          r_bit   <= '0;
          r_shift <= '0;
          r_sclk  <= 1'b1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          // MISO is taken at the end of each SCLK high half
          if (r_sclk) begin
            r_sclk <= 1'b0;
            if ((r_bit >= c_LEAD) && (r_bit < c_DATA_END)) begin
              r_shift <= {r_shift[ADC_BITS-2:0], io_cap.adc_miso};
            end
          end else if (r_bit == c_LAST_BIT) begin
            r_cs_n  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bit  <= r_bit + c_BW'(1);
            r_sclk <= 1'b1;
          end
        end
        S_DONE: begin
          r_next_idx <= r_next_idx + 8'd1;
          if (!w_push_ok && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_500k) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge i_clk_500k) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_data   <= '0;
      r_index  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
      // Head register: the incoming entry bypasses memory when nothing else remains
      if (w_level_next != '0) begin
        if (w_keep == '0) begin
          {r_data, r_index} <= w_entry;
        end else begin
          {r_data, r_index} <= r_mem[w_rd_next];
        end
      end
    end
  end

  assign io_cap.adc_cs_n      = r_cs_n;
  assign io_cap.adc_sclk      = r_sclk;
  assign io_cap.sample_data   = r_data;
  assign io_cap.sample_index  = r_index;
  assign io_cap.sample_valid  = (r_level != '0);
  assign io_cap.fifo_level    = r_level;
  assign io_cap.missed_count  = r_missed;
  assign io_cap.overrun_count = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sample_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sample_capture : directed bench with a timeline/queue model        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sample_capture;
  localparam int ADC_BITS   = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int FRAME_LEN  = 34;  // SETUP + 32 shift cycles + DONE

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_capture_if #(.ADC_BITS(ADC_BITS), .FIFO_DEPTH(FIFO_DEPTH)) cap_if ();

  sample_capture #(
    .ADC_BITS(ADC_BITS), .LEAD_BITS(3), .FRAME_BITS(16), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk_500k(clk),
    .i_rst_n   (rst_n),
    .io_cap    (cap_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ok = 0;
  int          n_edge = 0;
  logic        m_do_prev;
  bit          m_busy;
  int          m_start;
  logic [11:0] m_cur_adc;
  logic [11:0] next_adc = 12'h000;
  logic [11:0] q_d[$];
  logic [7:0]  q_i[$];
  logic [11:0] m_head_d;
  logic [7:0]  m_head_i;
  int          m_missed, m_overrun, m_next_idx;

  always @(posedge clk) begin
    bit trig, pop, was_busy;
    n_edge++;
    if (!rst_n) begin
      m_ok = 1; m_busy = 0; m_do_prev = cap_if.do_sample;
      q_d.delete(); q_i.delete();
      m_head_d = '0; m_head_i = '0;
      m_missed = 0; m_overrun = 0; m_next_idx = 0;
    end else if (m_ok) begin
      trig = (cap_if.do_sample !== m_do_prev);
      m_do_prev = cap_if.do_sample;
      pop = (q_d.size() > 0) && cap_if.sample_ready;
      was_busy = m_busy;
      if (pop) begin void'(q_d.pop_front()); void'(q_i.pop_front()); end
      if (m_busy && (n_edge - m_start == FRAME_LEN)) begin
        if (q_d.size() < FIFO_DEPTH) begin
          q_d.push_back(m_cur_adc); q_i.push_back(8'(m_next_idx));
        end else if (m_overrun < 255) m_overrun++;
        m_next_idx = (m_next_idx + 1) % 256;
        m_busy = 0;
      end
      if (trig) begin
        if (was_busy) begin
          if (m_missed < 255) m_missed++;
        end else begin
          m_busy = 1; m_start = n_edge; m_cur_adc = next_adc;
        end
      end
      if (q_d.size() > 0) begin m_head_d = q_d[0]; m_head_i = q_i[0]; end
    end
  end

  // ADC: lead bits 101, data MSB-first, trailing 1; bit k presented during the k-th SCLK high half
  always @(negedge clk) begin
    int m;
    logic [15:0] frame;
    cap_if.adc_miso = 1'b0;
    if (m_ok && m_busy) begin
      m = n_edge - m_start;
      frame = {3'b101, m_cur_adc, 1'b1};
      if ((m % 2 == 1) && m <= 31) cap_if.adc_miso = frame[15 - (m - 1) / 2];
    end
  end

  always @(negedge clk) begin
    int m;
    logic exp_cs, exp_sclk;
    if (m_ok) begin
      exp_cs = 1'b1; exp_sclk = 1'b0;
      if (m_busy) begin
        m = n_edge - m_start;
        if (m <= 32) exp_cs = 1'b0;
        if (m >= 1 && m <= 32 && (m % 2 == 1)) exp_sclk = 1'b1;
      end
      chk("cs_n",    cap_if.adc_cs_n,      exp_cs);
      chk("sclk",    cap_if.adc_sclk,      exp_sclk);
      chk("valid",   cap_if.sample_valid,  (q_d.size() > 0));
      chk("level",   cap_if.fifo_level,    q_d.size());
      chk("data",    cap_if.sample_data,   m_head_d);
      chk("index",   cap_if.sample_index,  m_head_i);
      chk("missed",  cap_if.missed_count,  m_missed);
      chk("overrun", cap_if.overrun_count, m_overrun);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    cap_if.do_sample = ~cap_if.do_sample;
  endtask

  initial begin
    int cs_low, pulses, rise_at;
    logic prev_s, prev_cs;
    cap_if.do_sample    = 1'b0;
    cap_if.sample_ready = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("rst_cs_n", cap_if.adc_cs_n, 1);
    chk("rst_sclk", cap_if.adc_sclk, 0);
    chk("rst_valid", cap_if.sample_valid, 0);
    chk("rst_level", cap_if.fifo_level, 0);
    chk("rst_data", cap_if.sample_data, 0);
    chk("rst_index", cap_if.sample_index, 0);
    chk("rst_missed", cap_if.missed_count, 0);
    chk("rst_overrun", cap_if.overrun_count, 0);
    cyc(5);

    // single trigger
    next_adc = 12'hABC;
    cs_low = 0; pulses = 0; rise_at = -1; prev_s = 1'b0; prev_cs = 1'b1;
    toggle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cap_if.adc_cs_n === 1'b0) cs_low++;
      if (cap_if.adc_sclk === 1'b1 && prev_s === 1'b0) pulses++;
      prev_s = cap_if.adc_sclk;
      if (cap_if.adc_cs_n === 1'b1 && prev_cs === 1'b0) rise_at = i;
      if (rise_at >= 0 && i == rise_at + 1) begin
        chk("single_valid", cap_if.sample_valid, 1);
        chk("single_data", cap_if.sample_data, 12'hABC);
        chk("single_index", cap_if.sample_index, 0);
      end
      prev_cs = cap_if.adc_cs_n;
    end
    chk("single_cs_low_cycles", cs_low, 33);
    chk("single_sclk_pulses", pulses, 16);
    chk("single_cs_rise", rise_at, 33);
    cap_if.sample_ready = 1'b1; cyc(1); cap_if.sample_ready = 1'b0;
    chk("pop_valid", cap_if.sample_valid, 0);
    chk("pop_level", cap_if.fifo_level, 0);

    // busy trigger
    next_adc = 12'h123; toggle(); cyc(10); toggle(); cyc(40);
    chk("busy_missed", cap_if.missed_count, 1);
    chk("busy_level", cap_if.fifo_level, 1);
    chk("busy_data", cap_if.sample_data, 12'h123);
    next_adc = 12'h5A5; toggle(); cyc(40);
    chk("busy_next_level", cap_if.fifo_level, 2);
    cap_if.sample_ready = 1'b1; cyc(1);
    chk("busy_next_index", cap_if.sample_index, 2);
    chk("busy_next_data", cap_if.sample_data, 12'h5A5);
    cyc(1); cap_if.sample_ready = 1'b0;
    chk("empty_holds_index", cap_if.sample_index, 2);

    // FIFO full: indices 3..18 kept, 19 dropped
    for (int i = 0; i < 17; i++) begin
      next_adc = 12'(i * 291 + 7); toggle(); cyc(40);
    end
    chk("full_level", cap_if.fifo_level, 16);
    chk("full_overrun", cap_if.overrun_count, 1);
    cap_if.sample_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_index", cap_if.sample_index, 3 + i);
      cyc(1);
    end
    cap_if.sample_ready = 1'b0;
    chk("drained_valid", cap_if.sample_valid, 0);
    next_adc = 12'hFED; toggle(); cyc(40);
    chk("after_gap_index", cap_if.sample_index, 20);
    cap_if.sample_ready = 1'b1; cyc(1); cap_if.sample_ready = 1'b0;

    // full with pop in the DONE cycle: indices 21..36 then 37
    for (int i = 0; i < 16; i++) begin
      next_adc = 12'(i * 53 + 1); toggle(); cyc(40);
    end
    next_adc = 12'h777; toggle(); cyc(34);
    cap_if.sample_ready = 1'b1; cyc(1); cap_if.sample_ready = 1'b0;
    chk("fullpop_level", cap_if.fifo_level, 16);
    chk("fullpop_overrun", cap_if.overrun_count, 1);
    chk("fullpop_head", cap_if.sample_index, 22);
    cap_if.sample_ready = 1'b1; cyc(15); cap_if.sample_ready = 1'b0;
    chk("fullpop_last_index", cap_if.sample_index, 37);
    chk("fullpop_last_data", cap_if.sample_data, 12'h777);
    cap_if.sample_ready = 1'b1; cyc(1); cap_if.sample_ready = 1'b0;

    // reset mid-frame with one entry held
    next_adc = 12'h321; toggle(); cyc(40);
    toggle(); cyc(13);
    chk("midframe_cs_low", cap_if.adc_cs_n, 0);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    chk("abort_cs_n", cap_if.adc_cs_n, 1);
    chk("abort_sclk", cap_if.adc_sclk, 0);
    chk("abort_level", cap_if.fifo_level, 0);
    chk("abort_missed", cap_if.missed_count, 0);
    chk("abort_overrun", cap_if.overrun_count, 0);
    cyc(50);
    chk("no_false_trig", cap_if.adc_cs_n, 1);
    chk("no_false_push", cap_if.fifo_level, 0);

    // index wrap at minimum trigger spacing
    cap_if.sample_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      next_adc = 12'(i * 13); toggle(); cyc(35);
    end
    chk("wrap_index", cap_if.sample_index, 3);
    chk("min_spacing_missed", cap_if.missed_count, 0);
    cyc(2);
    chk("wrap_index_held", cap_if.sample_index, 3);
    toggle(); cyc(34); toggle(); cyc(40);
    chk("done_edge_missed", cap_if.missed_count, 1);

    // saturation of missed counter
    for (int i = 0; i < 310; i++) begin
      toggle(); cyc(1);
    end
    cyc(40);
    chk("missed_saturated", cap_if.missed_count, 255);
    toggle(); cyc(5); toggle(); cyc(40);
    chk("missed_held", cap_if.missed_count, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
